// File: rtl/primogen_pkg.sv
// Shared types for the primogen collector: result width, FSM states, count type.
package primogen_pkg;

    localparam int PRIMO_WIDTH = 16;

    typedef logic [31:0] count_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_LOW,
        WAIT_HIGH,
        HALT
    } collector_state_t;

endpackage

// File: rtl/primogen_collector_if.sv
// Downstream valid/ready result stream of the primogen collector.
interface primogen_collector_if
    import primogen_pkg::*;
#(
    parameter int WIDTH = PRIMO_WIDTH
);
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/primo_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head is zero while empty.
// The caller must not push into a full FIFO unless it pops in the same cycle.
module primo_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_pop;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        count    = wr_ptr_q - rd_ptr_q;
        head     = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/primogen_collector.sv
// Hardware initiator for primogen: requests primes, buffers them, streams them out.
// Optional PRIMOGEN_COLLECTOR_ORDER_CHECK_EN adds a sticky non-increasing result flag.
module primogen_collector
    import primogen_pkg::*;
#(
    parameter int          WIDTH     = PRIMO_WIDTH,
    parameter int          DEPTH     = 4,
    parameter logic [31:0] MAX_COUNT = 32'hFFFF_FFFF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    output logic                   gen_go,
    input  logic                   gen_ready,
    input  logic                   gen_error,
    input  logic [WIDTH-1:0]       gen_res,
    primogen_collector_if.master   out_if,
    output count_t                 res_count,
    output logic                   overflow,
    output logic                   done,
    output logic                   busy
`ifdef PRIMOGEN_COLLECTOR_ORDER_CHECK_EN
    ,
    output logic                   order_error
`endif
);
    localparam int AW = $clog2(DEPTH);

    collector_state_t state_q, state_d;
    count_t           res_count_q, res_count_d;
    logic             overflow_q, overflow_d;
    logic             done_q, done_d;
    logic             push, pop, slot_ok;
    logic             fifo_empty, fifo_full;
    logic [AW:0]      fifo_count;
    logic [WIDTH-1:0] fifo_head;
`ifdef PRIMOGEN_COLLECTOR_ORDER_CHECK_EN
    logic             order_error_q, order_error_d;
    logic [WIDTH-1:0] last_q, last_d;
`endif

    primo_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (gen_res),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign out_if.out_data  = fifo_head;
    assign out_if.out_valid = !fifo_empty;
    assign pop              = !fifo_empty && out_if.out_ready;
    // A same-cycle pop frees the slot the upcoming result will use.
    assign slot_ok          = (fifo_count < (AW+1)'(DEPTH)) || pop;

    always_comb begin
        state_d     = state_q;
        res_count_d = res_count_q;
        overflow_d  = overflow_q;
        done_d      = done_q;
        push        = 1'b0;
        gen_go      = 1'b0;
        busy        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable && !done_q && gen_ready && slot_ok) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                gen_go  = 1'b1;
                busy    = 1'b1;
                state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                busy = 1'b1;
                if (!gen_ready) begin
                    state_d = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                busy = 1'b1;
                if (gen_ready && gen_error) begin
                    overflow_d = 1'b1;
                    done_d     = 1'b1;
                    state_d    = HALT;
                end else if (gen_ready) begin
                    push        = !fifo_full || pop;
                    res_count_d = res_count_q + 32'd1;
                    done_d      = (res_count_d == MAX_COUNT);
                    state_d     = done_d ? HALT : IDLE;
                end
            end
            HALT: state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

`ifdef PRIMOGEN_COLLECTOR_ORDER_CHECK_EN
    always_comb begin
        order_error_d = order_error_q;
        last_d        = last_q;
        if (push) begin
            last_d = gen_res;
            if (res_count_q != '0 && gen_res <= last_q) begin
                order_error_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            order_error_q <= 1'b0;
            last_q        <= '0;
        end else begin
            order_error_q <= order_error_d;
            last_q        <= last_d;
        end
    end

    assign order_error = order_error_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            res_count_q <= '0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            res_count_q <= res_count_d;
            overflow_q  <= overflow_d;
            done_q      <= done_d;
        end
    end

    assign res_count = res_count_q;
    assign overflow  = overflow_q;
    assign done      = done_q;

endmodule

// File: tb/tb_primogen_collector.sv
// Bench for primogen_collector: behavioural primogen stubs, prime reference model.
module tb_primogen_collector;

    logic        clk;
    logic        rst0, rst1, en0, en1;
    logic [1:0]  go, rdy, err, srst;
    logic [15:0] res [2];
    logic [31:0] rc0, rc1;
    logic        ovf0, ovf1, dn0, dn1, bz0, bz1;
`ifdef PRIMOGEN_COLLECTOR_ORDER_CHECK_EN
    logic        oe0, oe1;
`endif

    int          idx [2];
    int          lat [2];
    int          err_at [2];
    int          lat_fix;
    logic [15:0] seq_tab [2][64];

    logic [15:0] obs0[$];
    logic [15:0] obs1[$];
    int          gocnt0, gocnt1, gap0, gap1, bad0, bad1;
    int          total, passed, failed, c0;

    primogen_collector_if #(.WIDTH(16)) oif0 ();
    primogen_collector_if #(.WIDTH(16)) oif1 ();

    primogen_collector #(.WIDTH(16), .DEPTH(4)) u0 (
        .clk(clk), .rst(rst0), .enable(en0), .gen_go(go[0]),
        .gen_ready(rdy[0]), .gen_error(err[0]), .gen_res(res[0]),
        .out_if(oif0), .res_count(rc0), .overflow(ovf0),
        .done(dn0), .busy(bz0)
`ifdef PRIMOGEN_COLLECTOR_ORDER_CHECK_EN
        , .order_error(oe0)
`endif
    );

    primogen_collector #(.WIDTH(16), .DEPTH(4), .MAX_COUNT(32'd3)) u1 (
        .clk(clk), .rst(rst1), .enable(en1), .gen_go(go[1]),
        .gen_ready(rdy[1]), .gen_error(err[1]), .gen_res(res[1]),
        .out_if(oif1), .res_count(rc1), .overflow(ovf1),
        .done(dn1), .busy(bz1)
`ifdef PRIMOGEN_COLLECTOR_ORDER_CHECK_EN
        , .order_error(oe1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural primogen: ready drops after go, result appears after lat cycles.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (srst[k]) begin
                rdy[k] <= 1'b1;
                err[k] <= 1'b0;
                res[k] <= '0;
                idx[k] <= 0;
                lat[k] <= 0;
            end else if (go[k] && rdy[k]) begin
                rdy[k] <= 1'b0;
                lat[k] <= (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 6));
            end else if (!rdy[k]) begin
                if (lat[k] <= 1) begin
                    rdy[k] <= 1'b1;
                    res[k] <= seq_tab[k][idx[k]];
                    err[k] <= (idx[k] + 1 == err_at[k]);
                    idx[k] <= idx[k] + 1;
                end else begin
                    lat[k] <= lat[k] - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst0) begin
            gap0 = 100;
        end else begin
            if (oif0.out_valid && oif0.out_ready) obs0.push_back(oif0.out_data);
            if (go[0]) begin
                gocnt0++;
                if (gap0 < 3) bad0++;
                gap0 = 0;
            end else begin
                gap0++;
            end
        end
        if (rst1) begin
            gap1 = 100;
        end else begin
            if (oif1.out_valid && oif1.out_ready) obs1.push_back(oif1.out_data);
            if (go[1]) begin
                gocnt1++;
                if (gap1 < 3) bad1++;
                gap1 = 0;
            end else begin
                gap1++;
            end
        end
    end

    function automatic int nth_prime(input int n);
        int c = 0;
        for (int p = 2; p < 1000; p++) begin
            bit is_p = 1'b1;
            for (int d = 2; d * d <= p; d++) if (p % d == 0) is_p = 1'b0;
            if (is_p) begin
                if (c == n) return p;
                c++;
            end
        end
        return 0;
    endfunction

    function automatic logic [31:0] at0(input int i);
        if (i < obs0.size()) return 32'(obs0[i]);
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] at1(input int i);
        if (i < obs1.size()) return 32'(obs1[i]);
        return 32'hFFFF_FFFF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait0(input int n, input string tag);
        int i = 0;
        while (rc0 != 32'(n) && i < 300) begin
            cyc(1);
            i++;
        end
        chk(tag, rc0, 32'(n));
    endtask

    task automatic stream0(input int first, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            chk(tag, at0(c0), 32'(nth_prime(first + i)));
            c0++;
        end
        chk({tag, "_len"}, 32'(obs0.size()), 32'(c0));
    endtask

    task automatic rst_checks(input string tag);
        chk({tag, "_go"}, 32'(go[0]), 0);
        chk({tag, "_valid"}, 32'(oif0.out_valid), 0);
        chk({tag, "_data"}, 32'(oif0.out_data), 0);
        chk({tag, "_count"}, rc0, 0);
        chk({tag, "_ovf"}, 32'(ovf0), 0);
        chk({tag, "_done"}, 32'(dn0), 0);
        chk({tag, "_busy"}, 32'(bz0), 0);
    endtask

    initial begin
        int g, i, n;
        total = 0; passed = 0; failed = 0; c0 = 0;
        gocnt0 = 0; gocnt1 = 0; bad0 = 0; bad1 = 0; gap0 = 100; gap1 = 100;
        rst0 = 1'b1; rst1 = 1'b1; srst = 2'b11; en0 = 1'b0; en1 = 1'b0;
        oif0.out_ready = 1'b0; oif1.out_ready = 1'b0;
        lat_fix = 5; err_at[0] = 0; err_at[1] = 0;
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < 64; j++) seq_tab[k][j] = 16'(nth_prime(j));
        cyc(3);
        rst_checks("rst");
        chk("rst_count1", rc1, 0);
        rst0 = 1'b0; rst1 = 1'b0; srst = 2'b00;

        // Free-running stream 2,3,5,7,11
        oif0.out_ready = 1'b1; en0 = 1'b1;
        wait0(5, "a_count");
        en0 = 1'b0;
        cyc(10);
        stream0(0, 5, "a_data");
        chk("a_gocnt", 32'(gocnt0), 5);

        // Backpressure: four requests fill the FIFO, then nothing more
        oif0.out_ready = 1'b0; en0 = 1'b1;
        cyc(80);
        chk("b_gocnt", 32'(gocnt0), 9);
        chk("b_count", rc0, 9);
        chk("b_valid", 32'(oif0.out_valid), 1);
        chk("b_nodata", 32'(obs0.size()), 32'(c0));
        oif0.out_ready = 1'b1;
        wait0(12, "b_count2");
        en0 = 1'b0;
        cyc(10);
        stream0(5, 7, "b_data");
        chk("b_gocnt2", 32'(gocnt0), 12);

        // Random backpressure, random enable, random generator latency
        lat_fix = 0;
        repeat (150) begin
            oif0.out_ready = 1'($urandom_range(0, 1));
            en0 = ($urandom_range(0, 3) != 0);
            cyc(1);
        end
        en0 = 1'b0; oif0.out_ready = 1'b1;
        cyc(20);
        chk("r_busy", 32'(bz0), 0);
        chk("r_gocnt", 32'(gocnt0), rc0);
        n = int'(rc0) - 12;
        stream0(12, n, "r_data");

        // Overflow on the third request
        rst0 = 1'b1; srst[0] = 1'b1; lat_fix = 5; err_at[0] = 3;
        cyc(2);
        rst0 = 1'b0; srst[0] = 1'b0;
        g = gocnt0;
        oif0.out_ready = 1'b0; en0 = 1'b1;
        i = 0;
        while (!dn0 && i < 200) begin cyc(1); i++; end
        chk("c_done", 32'(dn0), 1);
        chk("c_ovf", 32'(ovf0), 1);
        chk("c_count", rc0, 2);
        cyc(30);
        chk("c_gocnt", 32'(gocnt0 - g), 3);
        chk("c_busy", 32'(bz0), 0);
        oif0.out_ready = 1'b1;
        cyc(10);
        stream0(0, 2, "c_data");
        chk("c_done_hold", 32'(dn0), 1);

        // MAX_COUNT = 3 instance
        en1 = 1'b1; oif1.out_ready = 1'b1;
        i = 0;
        while (!dn1 && i < 200) begin cyc(1); i++; end
        chk("d_done", 32'(dn1), 1);
        chk("d_ovf", 32'(ovf1), 0);
        chk("d_count", rc1, 3);
        cyc(30);
        chk("d_gocnt", 32'(gocnt1), 3);
        for (int j = 0; j < 3; j++) chk("d_data", at1(j), 32'(nth_prime(j)));
        chk("d_len", 32'(obs1.size()), 3);

        // Reset while waiting for the result: that result is abandoned
        rst0 = 1'b1; srst[0] = 1'b1; err_at[0] = 0;
        cyc(2);
        rst0 = 1'b0; srst[0] = 1'b0; en0 = 1'b1;
        i = 0;
        while (!go[0] && i < 50) begin cyc(1); i++; end
        chk("e_go", 32'(go[0]), 1);
        cyc(2);
        chk("e_wait_busy", 32'(bz0), 1);
        chk("e_wait_rdy", 32'(rdy[0]), 0);
        rst0 = 1'b1;
        cyc(1);
        rst_checks("e_rst");
        rst0 = 1'b0;
        wait0(2, "e_count");
        en0 = 1'b0;
        cyc(10);
        stream0(1, 2, "e_data");

        // Duplicate result 2,3,3
        rst0 = 1'b1; srst[0] = 1'b1;
        cyc(2);
        seq_tab[0][2] = 16'd3;
        rst0 = 1'b0; srst[0] = 1'b0; en0 = 1'b1;
        wait0(2, "f_count2");
`ifdef PRIMOGEN_COLLECTOR_ORDER_CHECK_EN
        chk("f_oe_pre", 32'(oe0), 0);
`endif
        wait0(3, "f_count3");
        en0 = 1'b0;
`ifdef PRIMOGEN_COLLECTOR_ORDER_CHECK_EN
        chk("f_oe", 32'(oe0), 1);
`endif
        cyc(10);
        chk("f_d0", at0(c0), 2);
        chk("f_d1", at0(c0 + 1), 3);
        chk("f_d2", at0(c0 + 2), 3);
        chk("f_len", 32'(obs0.size()), 32'(c0 + 3));

        chk("go_gap0", 32'(bad0), 0);
        chk("go_gap1", 32'(bad1), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/primogen_collector.md
Name: primogen_collector

Overview:
- Synthesizable initiator for the primogen go/ready/error handshake. Replaces the simulation-only driver loop with hardware.
- Repeatedly requests the next prime, buffers results in a small FIFO, and presents them downstream on a valid/ready stream.
- Stops cleanly when the generator reports overflow. Sits between primogen and any consumer (UART/display/logic).

Parameters:
- WIDTH, 16, result width; must match primogen res.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- MAX_COUNT, 32'hFFFF_FFFF, stop after this many primes collected.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- enable  in  1  level; when low, no new request is issued (in-flight request completes)
- gen_go  out  1  one-cycle request pulse to primogen go
- gen_ready  in  1  primogen ready; high = idle/result valid
- gen_error  in  1  primogen error; qualified by gen_ready
- gen_res  in  WIDTH  primogen result; qualified by gen_ready
- out_data  out  WIDTH  FIFO head
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head when out_valid && out_ready
- res_count  out  32  primes pushed into FIFO since reset
- overflow  out  1  sticky; generator reported error
- done  out  1  sticky; collection finished (overflow or MAX_COUNT reached)
- busy  out  1  request in flight

Behaviour:
- Reset (synchronous, rst sampled high at posedge clk): all outputs 0. FIFO empty. FSM to IDLE. Reset mid-request abandons it. A gen_ready rise seen after reset is ignored unless the request was issued after reset.
- FSM states:
  - IDLE
    - -> ISSUE when enable && !done && gen_ready && (fifo not full, counting a same-cycle pop as freeing a slot).
  - ISSUE
    - gen_go=1 for exactly this cycle; busy=1.
    - -> WAIT_LOW.
  - WAIT_LOW
    - Waits for gen_ready==0; busy=1.
    - -> WAIT_HIGH.
  - WAIT_HIGH
    - busy=1. On the first cycle gen_ready==1, capture gen_res/gen_error.
    - If gen_error: overflow<=1, done<=1, no push, -> HALT.
    - Else: push gen_res, res_count+1. If the new count == MAX_COUNT, done<=1 and -> HALT; else -> IDLE.
  - HALT
    - Terminal until rst. gen_go stays 0. FIFO still drains.
- Request rate: at most one request per 4 cycles (IDLE, ISSUE, WAIT_LOW >= 1, WAIT_HIGH >= 1).
- Push latency: result enters the FIFO at the posedge after gen_ready is seen high. out_valid rises the following cycle (registered FIFO, 1-cycle read latency from push).
- FIFO boundaries:
  - Push and pop in the same cycle on a full FIFO is legal; occupancy is unchanged.
  - Pop on empty is ignored.
  - Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
  - A request is never issued unless a slot is guaranteed, so a push never hits a full FIFO.
- res_count never wraps: the MAX_COUNT stop guarantees this.
- enable dropping mid-request has no effect until the FSM returns to IDLE.
- gen_error observed with gen_ready high while in IDLE is ignored. It is acted on only in WAIT_HIGH.

Optional Feature:
- Macro: PRIMOGEN_COLLECTOR_ORDER_CHECK_EN.
- Defined:
  - Adds output order_error (1 bit, sticky, reset 0).
  - Set when a pushed result is <= the previously pushed result. Comparison is unsigned; the first push after reset is always accepted.
  - Collection continues after order_error is set.
- Undefined: the port and comparator logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package primogen_pkg holds:
  - PRIMO_WIDTH = 16.
  - State typedef collector_state_t {IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, HALT}.
  - Count type of 32 bits.
- One sub-module: primo_fifo, a synchronous FIFO with params WIDTH and DEPTH. Ports: clk, rst, push, push_data, pop, head, empty, full, count.

Test Plan:
- Behavioural primogen stub (latency 5 cycles, sequence 2,3,5,7,11), enable=1, out_ready=1 -> out_data stream 2,3,5,7,11; gen_go pulses exactly 1 cycle each; res_count=5 after fifth push.
- out_ready=0 with DEPTH=4 -> exactly 4 requests issued, then gen_go stays 0; raise out_ready -> data 2,3,5,7 in order, requests resume.
- Stub asserts gen_error with ready on the 3rd request -> overflow=1, done=1, res_count=2, no third push; gen_go never pulses again; FIFO drains 2,3.
- MAX_COUNT=3 -> done=1 after pushing 5, overflow=0, no 4th gen_go.
- rst asserted during WAIT_HIGH -> next cycle all outputs 0 and FIFO empty; the late gen_ready rise is not pushed; after rst drops, first output is the stub's next value.
- With PRIMOGEN_COLLECTOR_ORDER_CHECK_EN, stub sequence 2,3,3 -> order_error=1 on the third push; without the macro, order_error is absent and the stream is 2,3,3.
